// File: rtl/cbd_sample_scheduler.sv
// cbd_sample_scheduler: sequences CBD sampler jobs, one polynomial at a time,
// supplying seed/nonce, RAM offset and eta selection for each polynomial.
`default_nettype none

module cbd_sample_scheduler #(
    parameter int K       = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         mode,
    input  logic [255:0] seed,
    input  logic [7:0]   base_offset,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [3:0]   poly_idx,
    output logic         samp_clr,
    output logic         samp_active,
    output logic [263:0] samp_M,
    output logic [7:0]   samp_offset,
    output logic [1:0]   samp_n_num,
    input  logic         samp_enw
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_LAUNCH = 3'd2,
        S_WAIT   = 3'd3,
        S_NEXT   = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    state_t         state;
    logic           mode_q;
    logic [255:0]   seed_q;
    logic [5:0]     wr_cnt;
    logic [TW-1:0]  t_cnt;
    logic [3:0]     total;
    logic [3:0]     next_idx;

    assign total    = mode_q ? 4'(2 * K + 1) : 4'(2 * K);
    assign next_idx = poly_idx + 4'd1;

    assign busy        = (state == S_CLEAR) || (state == S_LAUNCH) ||
                         (state == S_WAIT)  || (state == S_NEXT);
    assign done        = (state == S_DONE);
    assign samp_clr    = (state == S_CLEAR);
    assign samp_active = (state == S_LAUNCH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            mode_q      <= 1'b0;
            seed_q      <= '0;
            wr_cnt      <= '0;
            t_cnt       <= '0;
            err         <= 1'b0;
            poly_idx    <= '0;
            samp_M      <= '0;
            samp_offset <= '0;
            samp_n_num  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_CLEAR;
                        mode_q      <= mode;
                        seed_q      <= seed;
                        err         <= 1'b0;
                        poly_idx    <= 4'd0;
                        samp_M      <= {seed, 8'd0};
                        samp_offset <= base_offset;
                        samp_n_num  <= 2'd1;
                    end
                end
                S_CLEAR: begin
                    wr_cnt <= '0;
                    state  <= S_LAUNCH;
                end
                S_LAUNCH: begin
                    t_cnt <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (samp_enw) begin
                        wr_cnt <= wr_cnt + 6'd1;
                    end
                    t_cnt <= t_cnt + 1'b1;
                    // A 32nd write landing on the timeout cycle still wins.
                    if (samp_enw && wr_cnt == 6'd31) begin
                        state <= S_NEXT;
                    end else if (t_cnt == TW'(TIMEOUT - 1)) begin
                        state <= S_ERR;
                        err   <= 1'b1;
                    end
                end
                S_NEXT: begin
                    if (poly_idx < total - 4'd1) begin
                        state       <= S_CLEAR;
                        poly_idx    <= next_idx;
                        samp_M      <= {seed_q, 4'd0, next_idx};
                        samp_offset <= samp_offset + 8'd32;
                        samp_n_num  <= (mode_q && next_idx >= 4'(K)) ? 2'd2 : 2'd1;
                    end else begin
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cbd_sample_scheduler.sv
// Self-checking bench for cbd_sample_scheduler: three instances (K=2/3/4),
// a sampler model, and a scoreboard of expected per-polynomial launches.
`default_nettype none

module tb_cbd_sample_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         start;
    logic         mode;
    logic [255:0] seed;
    logic [7:0]   base;
    logic         enw;
    logic [1:0]   sel;

    logic         busy_a [3];
    logic         done_a [3];
    logic         err_a  [3];
    logic         clr_a  [3];
    logic         act_a  [3];
    logic [3:0]   idx_a  [3];
    logic [263:0] m_a    [3];
    logic [7:0]   off_a  [3];
    logic [1:0]   nn_a   [3];

    cbd_sample_scheduler #(.K(2), .TIMEOUT(100)) u_dut0 (
        .clk(clk), .rst(rst), .start(start && sel == 2'd0), .mode(mode), .seed(seed),
        .base_offset(base), .busy(busy_a[0]), .done(done_a[0]), .err(err_a[0]),
        .poly_idx(idx_a[0]), .samp_clr(clr_a[0]), .samp_active(act_a[0]), .samp_M(m_a[0]),
        .samp_offset(off_a[0]), .samp_n_num(nn_a[0]), .samp_enw(enw && sel == 2'd0));

    cbd_sample_scheduler #(.K(3)) u_dut1 (
        .clk(clk), .rst(rst), .start(start && sel == 2'd1), .mode(mode), .seed(seed),
        .base_offset(base), .busy(busy_a[1]), .done(done_a[1]), .err(err_a[1]),
        .poly_idx(idx_a[1]), .samp_clr(clr_a[1]), .samp_active(act_a[1]), .samp_M(m_a[1]),
        .samp_offset(off_a[1]), .samp_n_num(nn_a[1]), .samp_enw(enw && sel == 2'd1));

    cbd_sample_scheduler #(.K(4)) u_dut2 (
        .clk(clk), .rst(rst), .start(start && sel == 2'd2), .mode(mode), .seed(seed),
        .base_offset(base), .busy(busy_a[2]), .done(done_a[2]), .err(err_a[2]),
        .poly_idx(idx_a[2]), .samp_clr(clr_a[2]), .samp_active(act_a[2]), .samp_M(m_a[2]),
        .samp_offset(off_a[2]), .samp_n_num(nn_a[2]), .samp_enw(enw && sel == 2'd2));

    logic         m_busy, m_done, m_err, m_clr, m_act;
    logic [3:0]   m_idx;
    logic [263:0] m_M;
    logic [7:0]   m_off;
    logic [1:0]   m_nn;

    always_comb begin
        m_busy = busy_a[sel];
        m_done = done_a[sel];
        m_err  = err_a[sel];
        m_clr  = clr_a[sel];
        m_act  = act_a[sel];
        m_idx  = idx_a[sel];
        m_M    = m_a[sel];
        m_off  = off_a[sel];
        m_nn   = nn_a[sel];
    end

    typedef struct {
        logic [3:0]   idx;
        logic [7:0]   off;
        logic [1:0]   nn;
        logic [263:0] m;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   tests = 0;
    int   failed = 0;
    int   done_cnt = 0;
    int   stall_limit = 0;
    logic inj_launch = 1'b0;
    logic inj_idle = 1'b0;

    function automatic int kval(input logic [1:0] s);
        return (s == 2'd0) ? 2 : (s == 2'd1) ? 3 : 4;
    endfunction

    task automatic push_job(input int k, input logic md, input logic [255:0] sd,
                            input logic [7:0] b, input int n);
        exp_t e;
        for (int j = 0; j < n; j++) begin
            e.idx = 4'(j);
            e.off = 8'(int'(b) + 32 * j);
            e.nn  = (md && j >= k) ? 2'd2 : 2'd1;
            e.m   = {sd, 8'(j)};
            q.push_back(e);
        end
    endtask

    // Sampler model: after each launch, emits a burst of write strobes.
    initial begin
        int pending;
        enw = 1'b0;
        pending = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pending = 0;
                enw = 1'b0;
            end else if (m_act) begin
                pending = (stall_limit != 0) ? stall_limit : 32;
                enw = inj_launch;
            end else if (pending > 0) begin
                enw = 1'b1;
                pending--;
            end else begin
                enw = inj_idle;
            end
        end
    end

    // Scoreboard consumer: every launch must match the next expected polynomial.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && m_done) done_cnt++;
            if (!rst && m_act) begin
                if (q.size() == 0) begin
                    tests++; failed++;
                    $display("FAIL unexpected_launch: got launch idx=%0d, expected none", m_idx);
                end else begin
                    mon_e = q.pop_front();
                    tests++;
                    if (m_idx !== mon_e.idx) begin
                        failed++; $display("FAIL poly_idx: got %0d expected %0d", m_idx, mon_e.idx);
                    end
                    tests++;
                    if (m_off !== mon_e.off) begin
                        failed++; $display("FAIL samp_offset[%0d]: got %h expected %h", mon_e.idx, m_off, mon_e.off);
                    end
                    tests++;
                    if (m_nn !== mon_e.nn) begin
                        failed++; $display("FAIL samp_n_num[%0d]: got %0d expected %0d", mon_e.idx, m_nn, mon_e.nn);
                    end
                    tests++;
                    if (m_M !== mon_e.m) begin
                        failed++; $display("FAIL samp_M[%0d]: got %h expected %h", mon_e.idx, m_M[63:0], mon_e.m[63:0]);
                    end
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        tests++;
        if ({m_busy, m_done, m_err, m_clr, m_act} !== 5'b0 || m_M !== '0 ||
            m_off !== 8'd0 || m_nn !== 2'd0 || m_idx !== 4'd0) begin
            failed++;
            $display("FAIL %s: got busy=%b done=%b err=%b clr=%b act=%b off=%h nn=%0d idx=%0d, expected all 0",
                     tag, m_busy, m_done, m_err, m_clr, m_act, m_off, m_nn, m_idx);
        end
    endtask

    task automatic run_job(input logic md, input logic [255:0] sd, input logic [7:0] b,
                           input int stall, input logic inj);
        int k, n, d0, cyc;
        k = kval(sel);
        n = md ? 2 * k + 1 : 2 * k;
        d0 = done_cnt;
        stall_limit = stall;
        inj_launch = inj;
        push_job(k, md, sd, b, (stall != 0) ? 1 : n);
        mode = md; seed = sd; base = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (m_err !== 1'b0 || m_busy !== 1'b1 || m_clr !== 1'b1) begin
            failed++; $display("FAIL job_start: got err=%b busy=%b clr=%b expected 0/1/1", m_err, m_busy, m_clr);
        end
        cyc = 1;
        while (!m_done && !m_err && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        if (stall != 0) begin
            tests++;
            if (m_err !== 1'b1 || m_busy !== 1'b0) begin
                failed++; $display("FAIL timeout_err: got err=%b busy=%b expected 1/0", m_err, m_busy);
            end
            repeat (5) @(negedge clk);
            tests++;
            if (m_err !== 1'b1 || done_cnt !== d0) begin
                failed++; $display("FAIL err_sticky: got err=%b dones=%0d expected 1/%0d", m_err, done_cnt - d0, 0);
            end
        end else begin
            tests++;
            if (m_done !== 1'b1 || cyc !== 35 * n + 1) begin
                failed++; $display("FAIL job_latency: got done=%b cycles=%0d expected 1/%0d", m_done, cyc, 35 * n + 1);
            end
            tests++;
            if (m_busy !== 1'b0 || m_err !== 1'b0) begin
                failed++; $display("FAIL done_flags: got busy=%b err=%b expected 0/0", m_busy, m_err);
            end
            @(negedge clk);
            tests++;
            if (m_done !== 1'b0 || done_cnt !== d0 + 1) begin
                failed++; $display("FAIL done_pulse: got done=%b pulses=%0d expected 0/1", m_done, done_cnt - d0);
            end
        end
        tests++;
        if (q.size() != 0) begin
            failed++; $display("FAIL launches: got %0d missing launches expected 0", q.size());
        end
        stall_limit = 0;
        inj_launch = 1'b0;
    endtask

    task automatic test_reset();
        sel = 2'd0; rst = 1'b1; start = 1'b0; mode = 1'b0; seed = '0; base = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("idle_after_reset");
    endtask

    task automatic test_keygen_k2();
        sel = 2'd0;
        run_job(1'b0, {8{32'hA5A5_0001}}, 8'h00, 0, 1'b0);
    endtask

    task automatic test_encrypt_k3();
        sel = 2'd1;
        run_job(1'b1, {8{32'h1357_9BDF}}, 8'h10, 0, 1'b0);
    endtask

    task automatic test_keygen_k4_wrap();
        sel = 2'd2;
        run_job(1'b0, {8{32'hDEAD_BEEF}}, 8'h20, 0, 1'b0);
        repeat (40) @(negedge clk);
        tests++;
        if (m_busy !== 1'b0) begin
            failed++; $display("FAIL k4_idle: got busy=%b expected 0", m_busy);
        end
    endtask

    task automatic test_timeout();
        sel = 2'd0;
        run_job(1'b0, {8{32'h0BAD_F00D}}, 8'h40, 5, 1'b0);
        run_job(1'b0, {8{32'h7777_1111}}, 8'h40, 0, 1'b0);
    endtask

    task automatic test_start_while_busy();
        logic [255:0] sd;
        int guard, d0;
        sel = 2'd1;
        sd = {8{32'h2468_ACE0}};
        d0 = done_cnt;
        push_job(3, 1'b1, sd, 8'h00, 7);
        mode = 1'b1; seed = sd; base = 8'h00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (!(m_act && m_idx == 4'd1) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        repeat (5) @(negedge clk);
        seed = ~sd; mode = 1'b0; base = 8'h77; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (m_M !== {sd, 8'd1} || m_busy !== 1'b1) begin
            failed++; $display("FAIL busy_start_ignored: got M[7:0]=%h busy=%b expected 01/1", m_M[7:0], m_busy);
        end
        guard = 0;
        while (!m_done && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        tests++;
        if (done_cnt !== d0 + 1 || q.size() != 0) begin
            failed++; $display("FAIL busy_start_job: got dones=%0d pending=%0d expected 1/0", done_cnt - d0, q.size());
        end
    endtask

    task automatic test_rst_midjob();
        int d0;
        sel = 2'd0;
        d0 = done_cnt;
        push_job(2, 1'b0, {8{32'h5555_AAAA}}, 8'h80, 4);
        mode = 1'b0; seed = {8{32'h5555_AAAA}}; base = 8'h80; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        check_all_zero("reset_midjob");
        q.delete();
        rst = 1'b0;
        repeat (50) @(negedge clk);
        tests++;
        if (done_cnt !== d0 || m_busy !== 1'b0) begin
            failed++; $display("FAIL reset_no_done: got dones=%0d busy=%b expected 0/0", done_cnt - d0, m_busy);
        end
        run_job(1'b0, {8{32'hCAFE_0123}}, 8'h80, 0, 1'b0);
    endtask

    task automatic test_enw_inject();
        sel = 2'd0;
        inj_idle = 1'b1;
        repeat (3) @(negedge clk);
        inj_idle = 1'b0;
        run_job(1'b0, {8{32'h3C3C_9696}}, 8'hF0, 0, 1'b1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_keygen_k2();
        test_encrypt_k3();
        test_keygen_k4_wrap();
        test_timeout();
        test_start_while_busy();
        test_rst_midjob();
        test_enw_inject();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
